// File: rtl/clip_rr_pipe.sv
// Multi-flux pixel clipper: round-robin pick of one input FIFO per cycle, saturation
// to [0, 2^bit_depth-1], registered tagged output stage with stall hold, per-flux stats.
module clip_rr_pipe #(
   parameter int FLUX      = 2,
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 10,
   parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 0,
   parameter int CNT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [FLUX-1:0]                in_empty,
   output logic [FLUX-1:0]                in_read,
   input  logic [TAG_WIDTH+IN_WIDTH-1:0]  in_dout,
   input  logic [FLUX-1:0]                out_full,
   output logic                           out_write,
   output logic [TAG_WIDTH+OUT_WIDTH-1:0] out_din,
   input  logic [3:0]                     cfg_bit_depth,
   input  logic                           sat_clr,
   output logic [FLUX*CNT_WIDTH-1:0]      sat_hi_cnt,
   output logic [FLUX*CNT_WIDTH-1:0]      sat_lo_cnt
);

   // Handshake: a flux is popped (in_read) only when its FIFO is non-empty, its output
   // FIFO has room and the output stage is free; the held word leaves via out_write
   // whenever out_full of its own tag is low, and stays stable until then.

   localparam int TW = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
   localparam logic [3:0]           BD_MIN  = 4'd8;
   localparam logic [3:0]           BD_MAX  = 4'(OUT_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [IN_WIDTH:0]    ONE_EXT = (IN_WIDTH+1)'(1);
   localparam logic [TW-1:0]        LAST_IDX = TW'(FLUX - 1);

   logic                  out_valid;
   logic [TW-1:0]         tag_r;
   logic [OUT_WIDTH-1:0]  data_r;
   logic [TW-1:0]         rr_ptr;

   logic                  stage_free;
   logic [FLUX-1:0]       eligible;
   logic                  grant_vld;
   logic [TW-1:0]         grant_idx;

   logic [IN_WIDTH-1:0]   sample;
   logic [3:0]            bd_eff;
   logic [IN_WIDTH:0]     maxv;
   logic                  clip_hi;
   logic                  clip_lo;
   logic [OUT_WIDTH-1:0]  clip_val;

   logic [CNT_WIDTH-1:0]  hi_cnt [FLUX];
   logic [CNT_WIDTH-1:0]  lo_cnt [FLUX];

   // ------------------------------------------------------------------ drain / eligibility
   always_comb begin
      out_write  = out_valid & ~out_full[tag_r];
      stage_free = ~out_valid | out_write;
      eligible   = ~in_empty & ~out_full & {FLUX{stage_free & rst_n}};
   end

   // Round-robin search starting at rr_ptr; first eligible flux wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < FLUX; k++) begin
         if (!grant_vld && eligible[(int'(rr_ptr) + k) % FLUX]) begin
            grant_vld = 1'b1;
            grant_idx = TW'((int'(rr_ptr) + k) % FLUX);
         end
      end
   end

   always_comb begin
      in_read = '0;
      if (grant_vld) in_read[grant_idx] = 1'b1;
   end

   // ------------------------------------------------------------------ clip arithmetic
   always_comb begin
      sample   = in_dout[IN_WIDTH-1:0];
      bd_eff   = (cfg_bit_depth < BD_MIN || cfg_bit_depth > BD_MAX) ? BD_MAX : cfg_bit_depth;
      maxv     = (ONE_EXT << bd_eff) - ONE_EXT;
      clip_lo  = sample[IN_WIDTH-1];
      clip_hi  = ~clip_lo && ({1'b0, sample} > maxv);
      clip_val = sample[OUT_WIDTH-1:0];
      if (clip_hi)      clip_val = maxv[OUT_WIDTH-1:0];
      else if (clip_lo) clip_val = '0;
   end

   // ------------------------------------------------------------------ output stage
   // A grant always reloads the stage; that is legal because grants only happen when
   // the stage is empty or its word is being written on this same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         tag_r     <= '0;
         data_r    <= '0;
         rr_ptr    <= '0;
      end else begin
         if (grant_vld) begin
            out_valid <= 1'b1;
            tag_r     <= grant_idx;
            data_r    <= clip_val;
            rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + TW'(1);
         end else if (out_write) begin
            out_valid <= 1'b0;
         end
      end
   end

   generate
      if (TAG_WIDTH > 0) begin : g_tagged
         logic unused_in_tag;
         assign unused_in_tag = ^in_dout[TAG_WIDTH+IN_WIDTH-1:IN_WIDTH];
         assign out_din = {tag_r[TAG_WIDTH-1:0], data_r};
      end else begin : g_untagged
         assign out_din = data_r;
      end
   endgenerate

   // ------------------------------------------------------------------ saturation statistics
   // Counters stick at all-ones; a clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FLUX; i++) begin
            hi_cnt[i] <= '0;
            lo_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < FLUX; i++) begin
            if (sat_clr) begin
               hi_cnt[i] <= '0;
               lo_cnt[i] <= '0;
            end else if (grant_vld && grant_idx == TW'(i)) begin
               if (clip_hi && hi_cnt[i] != CNT_MAX) hi_cnt[i] <= hi_cnt[i] + CNT_WIDTH'(1);
               if (clip_lo && lo_cnt[i] != CNT_MAX) lo_cnt[i] <= lo_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      sat_hi_cnt = '0;
      sat_lo_cnt = '0;
      for (int i = 0; i < FLUX; i++) begin
         sat_hi_cnt[i*CNT_WIDTH +: CNT_WIDTH] = hi_cnt[i];
         sat_lo_cnt[i*CNT_WIDTH +: CNT_WIDTH] = lo_cnt[i];
      end
   end

endmodule

// File: tb/tb_clip_rr_pipe.sv
// Bench for clip_rr_pipe: queue-based FIFO models feed the DUT, a clamp/round-robin
// reference predicts every pop and output word, and a monitor pops expectations.
module tb_clip_rr_pipe;
   localparam int FLUX  = 2;
   localparam int IN_W  = 16;
   localparam int OUT_W = 10;
   localparam int TAG_W = 1;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // ------------------------------------------------------------------ clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                     rst_n = 1'b1;
   logic [FLUX-1:0]          in_empty = '1;
   logic [FLUX-1:0]          in_read;
   logic [TAG_W+IN_W-1:0]    in_dout = '0;
   logic [FLUX-1:0]          out_full = '0;
   logic                     out_write;
   logic [TAG_W+OUT_W-1:0]   out_din;
   logic [3:0]               cfg_bit_depth = 4'd10;
   logic                     sat_clr = 1'b0;
   logic [FLUX*CNT_W-1:0]    sat_hi_cnt;
   logic [FLUX*CNT_W-1:0]    sat_lo_cnt;

   clip_rr_pipe #(.FLUX(FLUX), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .CNT_WIDTH(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_read(in_read), .in_dout(in_dout),
      .out_full(out_full), .out_write(out_write), .out_din(out_din),
      .cfg_bit_depth(cfg_bit_depth), .sat_clr(sat_clr),
      .sat_hi_cnt(sat_hi_cnt), .sat_lo_cnt(sat_lo_cnt));

   // ------------------------------------------------------------------ model state
   int checks = 0;
   int errors = 0;
   logic [TAG_W+OUT_W-1:0] exp_q[$];
   int in_q[FLUX][$];
   int hi_m[FLUX];
   int lo_m[FLUX];
   int next_m = 0;              // flux that has first claim on the next grant
   logic [FLUX-1:0] full_v = '0;
   logic [3:0]      bd_v   = 4'd10;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FLUX*CNT_W-1:0] pack_cnt(input int c[FLUX]);
      logic [FLUX*CNT_W-1:0] r;
      r = '0;
      for (int f = 0; f < FLUX; f++) r[f*CNT_W +: CNT_W] = CNT_W'(c[f]);
      return r;
   endfunction

   // Clamp rule straight from the definition of the operation.
   function automatic int clip_ref(input int s, input int bd, output bit hi, output bit lo);
      int maxv;
      if (bd < 8 || bd > OUT_W) bd = OUT_W;
      maxv = (1 << bd) - 1;
      hi = (s > maxv);
      lo = (s < 0);
      if (hi) return maxv;
      if (lo) return 0;
      return s;
   endfunction

   // ------------------------------------------------------------------ driver
   task automatic cycle(input bit clr = 1'b0, input bit rst = 1'b0);
      int gf;
      int s;
      int v;
      bit hi;
      bit lo;
      logic [FLUX-1:0] exp_read;
      @(negedge clk);
      if (!rst) begin
         chk("sat_hi_cnt", sat_hi_cnt, pack_cnt(hi_m));
         chk("sat_lo_cnt", sat_lo_cnt, pack_cnt(lo_m));
         rst_n = 1'b1;
      end else begin
         rst_n = 1'b0;
         exp_q.delete();
         next_m = 0;
         for (int f = 0; f < FLUX; f++) begin
            hi_m[f] = 0;
            lo_m[f] = 0;
         end
      end
      out_full      = full_v;
      cfg_bit_depth = bd_v;
      sat_clr       = clr;
      for (int f = 0; f < FLUX; f++) in_empty[f] = (in_q[f].size() == 0);
      #1;
      if (rst) begin
         chk("rst_out_write", out_write, 0);
         chk("rst_out_din", out_din, 0);
         chk("rst_hi_cnt", sat_hi_cnt, 0);
         chk("rst_lo_cnt", sat_lo_cnt, 0);
      end
      gf = -1;
      if (rst_n && (exp_q.size() == 0 || !full_v[exp_q[0][OUT_W]])) begin
         for (int k = 0; k < FLUX; k++) begin
            int f;
            f = (next_m + k) % FLUX;
            if (gf < 0 && in_q[f].size() > 0 && !full_v[f]) gf = f;
         end
      end
      exp_read = '0;
      if (gf >= 0) exp_read[gf] = 1'b1;
      chk("in_read", in_read, exp_read);
      if (gf >= 0) begin
         s = in_q[gf][0];
         in_dout = {TAG_W'(gf), IN_W'(s)};
      end else begin
         in_dout = (TAG_W+IN_W)'($urandom);
      end
      #2;
      if (clr) begin
         for (int f = 0; f < FLUX; f++) begin
            hi_m[f] = 0;
            lo_m[f] = 0;
         end
      end
      if (gf >= 0) begin
         void'(in_q[gf].pop_front());
         v = clip_ref(s, int'(bd_v), hi, lo);
         exp_q.push_back({TAG_W'(gf), OUT_W'(v)});
         if (!clr && hi && hi_m[gf] < CMAX) hi_m[gf]++;
         if (!clr && lo && lo_m[gf] < CMAX) lo_m[gf]++;
         next_m = (gf + 1) % FLUX;
      end
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((in_q[0].size() + in_q[1].size() + exp_q.size()) > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_timeout", (in_q[0].size() + in_q[1].size() + exp_q.size()), 0);
   endtask

   // ------------------------------------------------------------------ monitor / scoreboard
   initial begin
      forever begin
         logic exp_w;
         @(negedge clk);
         #2;
         exp_w = (exp_q.size() > 0) && !out_full[exp_q[0][OUT_W]];
         chk("out_write", out_write, exp_w);
         if (exp_q.size() > 0) chk("out_din", out_din, exp_q[0]);
         if (exp_w) void'(exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------ stimulus
   initial begin
      for (int f = 0; f < FLUX; f++) begin
         hi_m[f] = 0;
         lo_m[f] = 0;
      end
      cycle(1'b0, 1'b1);
      cycle();

      // single flux, 8-bit depth
      bd_v = 4'd8;
      in_q[0].push_back(300);
      in_q[0].push_back(-5);
      in_q[0].push_back(128);
      run_until_idle(20);
      chk("t1_hi0", sat_hi_cnt[CNT_W-1:0], 1);
      chk("t1_lo0", sat_lo_cnt[CNT_W-1:0], 1);

      // both fluxes busy, no back-pressure: alternation
      bd_v = 4'd10;
      for (int i = 0; i < 8; i++) begin
         in_q[0].push_back(int'($urandom_range(0, 1500)));
         in_q[1].push_back(int'($urandom_range(0, 1500)) - 200);
      end
      run_until_idle(40);

      // 10-bit boundaries, then an illegal depth
      in_q[0].push_back(1023);
      in_q[0].push_back(1024);
      in_q[0].push_back(700);
      run_until_idle(20);
      bd_v = 4'd5;
      in_q[1].push_back(2000);
      run_until_idle(20);
      bd_v = 4'd10;

      // stall on flux 1 with flux 0 waiting
      in_q[1].push_back(500);
      cycle();
      full_v = 2'b10;
      for (int i = 0; i < 3; i++) in_q[0].push_back(int'($urandom_range(0, 2000)));
      repeat (5) cycle();
      full_v = 2'b00;
      run_until_idle(20);

      // counter saturation and clear priority
      bd_v = 4'd8;
      for (int i = 0; i < 20; i++) in_q[0].push_back(2000);
      run_until_idle(40);
      chk("sat_hi0_15", sat_hi_cnt[CNT_W-1:0], 15);
      in_q[0].push_back(2000);
      cycle(1'b1);
      cycle();
      chk("clr_hi0", sat_hi_cnt[CNT_W-1:0], 0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) != 0) begin
            int f;
            int s;
            f = int'($urandom_range(0, FLUX - 1));
            if ($urandom_range(0, 3) == 0) s = int'($signed(16'($urandom)));
            else s = int'($urandom_range(0, 2500)) - 300;
            in_q[f].push_back(s);
         end
         full_v = ($urandom_range(0, 3) == 0) ? FLUX'($urandom) : '0;
         bd_v = 4'($urandom_range(0, 15));
         cycle($urandom_range(0, 39) == 0);
      end
      full_v = '0;
      run_until_idle(600);

      // reset while a word is held under back-pressure
      bd_v = 4'd10;
      in_q[1].push_back(700);
      cycle();
      full_v = 2'b11;
      in_q[0].push_back(100);
      in_q[0].push_back(-1);
      in_q[1].push_back(1200);
      cycle();
      cycle();
      cycle(1'b0, 1'b1);
      full_v = 2'b00;
      run_until_idle(20);

      repeat (2) cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clip_rr_pipe.md
Name: clip_rr_pipe

Overview:
Multi-flux pixel clipper, next generation of the tagged single-cycle clip actor. It serves FLUX tagged input FIFOs with a round-robin arbiter. Each selected signed sample is saturated to [0, 2^bit_depth-1], with the bit depth chosen at run time. The result is written through a registered output stage with stall handling into tagged output FIFOs. Per-flux saturation counters provide statistics. It sits between the reconstruction adders and the picture buffer writers in the HEVC 8-pixel dataflow.

Parameters:
FLUX, 2, number of independent data fluxes (channels), >=1
IN_WIDTH, 16, signed input sample width
OUT_WIDTH, 10, maximum unsigned output width (upper bound of bit_depth)
TAG_WIDTH, $clog2(FLUX) (0 when FLUX==1), flux tag width carried in MSBs of din/dout
CNT_WIDTH, 16, saturation counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_empty  in  FLUX  per-flux input FIFO empty
in_read  out  FLUX  per-flux input FIFO read strobe (one-hot or zero)
in_dout  in  TAG_WIDTH+IN_WIDTH  input word, {tag, signed sample}, valid in the cycle in_read is asserted
out_full  in  FLUX  per-flux output FIFO full
out_write  out  1  output FIFO write strobe
out_din  out  TAG_WIDTH+OUT_WIDTH  output word, {tag, clipped sample}
cfg_bit_depth  in  4  active bit depth, legal 8..OUT_WIDTH
sat_clr  in  1  synchronous clear of all saturation counters
sat_hi_cnt  out  FLUX*CNT_WIDTH  per-flux count of samples clipped to max
sat_lo_cnt  out  FLUX*CNT_WIDTH  per-flux count of samples clipped to 0

Behaviour:
- Reset (rst_n low, async): in_read=0, out_write=0, out_din=0, out_valid register=0, rr pointer=0, all counters=0. Reset mid-transfer drops the held output word; no partial write is issued.
- Eligibility: flux i is eligible when in_empty[i]==0, out_full[i]==0 and the stage is free. The stage is free when out_valid==0, or when out_valid==1 and the held word is being written this cycle.
- Arbitration: round-robin starting at rr pointer. At most one in_read bit is set per cycle. After a grant to flux g, rr pointer becomes (g+1) mod FLUX. The pointer is unchanged when there is no grant.
- in_read is combinational from the registered state and current empty/full. Sample capture happens on the same edge as the FIFO pop.
- Clip arithmetic: maxv = 2^bit_depth - 1, zero-extended to IN_WIDTH+1.
  - sample > maxv: result = maxv; sat_hi_cnt[g] increments.
  - sample < 0: result = 0; sat_lo_cnt[g] increments.
  - otherwise: result = sample[OUT_WIDTH-1:0].
  - Output bits above bit_depth are 0.
- cfg_bit_depth is sampled at grant time, per sample. An illegal value (<8 or >OUT_WIDTH) is treated as OUT_WIDTH.
- Output stage: the registered word {g, result} and out_valid are set on the edge after the grant.
- out_write = out_valid & ~out_full[tag_r], combinational on the held tag. out_din is stable while out_valid is held.
- Latency: 1 cycle from in_read to out_write when not stalled.
- Throughput: 1 sample/cycle across all fluxes.
- Stall: if out_full[tag_r]==1, the word is held and out_write=0. Other fluxes cannot be granted while the stage is occupied and not draining, so no reordering and no word loss.
- Simultaneous drain and grant: the held word is written and the new word is loaded on the same edge.
- Counters: saturating at 2^CNT_WIDTH-1, with no wrap. sat_clr has priority over an increment in the same cycle.
- No combinational path from in_dout to out_din. out_din is only driven from registers.

Test Plan:
- Single flux, FLUX=2, bit_depth=8, inputs 300, -5, 128 on flux 0 -> out_din {0,255},{0,0},{0,128} one cycle after each read; sat_hi_cnt[0]=1, sat_lo_cnt[0]=1.
- Both fluxes always non-empty, outputs never full -> grants alternate 0,1,0,1; out_write high every cycle after the first; tags alternate accordingly.
- bit_depth=10, inputs 1023, 1024, 700 -> 1023, 1023 (hi count +1), 700. Then bit_depth=5 (illegal) with input 2000 -> 1023.
- Hold out_full[1]=1 for 5 cycles with a flux-1 word in the stage -> out_write=0, out_din constant, in_read=0 for all fluxes. On release the word is written the same cycle and the next grant occurs in that cycle.
- Counter saturation with CNT_WIDTH=4: 20 over-range samples -> sat_hi_cnt=15. Then assert sat_clr together with an over-range sample -> counter=0.
- Assert rst_n low while out_valid=1 and out_full set -> out_write=0, counters=0, rr pointer=0 immediately. After release, the first grant goes to flux 0 when all fluxes are eligible.
